// File: rtl/my_serial_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package my_serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/my_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while run is high and
// pulses tick on the last cycle of each period.
module my_bit_timer
   import my_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Dropping run restarts the period, so every bit begins at count zero.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (!run) begin
         cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
         tick  = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/my_serial_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, DATA_W data bits
// LSB first, stop bit, each held CLKS_PER_BIT cycles.
module my_serial_tx
   import my_serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   tx_state_e          state_q, state_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               tx_q, tx_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               tick;

   my_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (state_q != IDLE),
      .tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE: begin
            if (valid && ready_q) begin
               shreg_d   = din;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered line
   // changes on the same edge as the state it represents.
   always_comb begin
      tx_d    = IDLE_LVL;
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      case (state_d)
         IDLE:    tx_d = IDLE_LVL;
         START:   tx_d = START_LVL;
         DATA:    tx_d = shreg_d[0];
         STOP:    tx_d = STOP_LVL;
         default: tx_d = IDLE_LVL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         tx_q      <= IDLE_LVL;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   // The shift register only carries data; its contents are ignored outside a frame.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   assign tx    = tx_q;
   assign ready = ready_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_my_serial_tx.sv
// Bench for my_serial_tx: a frame-level model predicts the serial line cycle
// by cycle for a default instance and a minimal DATA_W=1, CLKS_PER_BIT=1 one.
module tb_my_serial_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int FL  = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] din = '0;
   logic          valid = 1'b0;
   logic          ready, tx, busy;

   logic          din2 = 1'b0;
   logic          valid2 = 1'b0;
   logic          ready2, tx2, busy2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   my_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .valid(valid),
      .ready(ready), .tx(tx), .busy(busy)
   );

   my_serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut_min (
      .clk(clk), .rst_n(rst_n), .din(din2), .valid(valid2),
      .ready(ready2), .tx(tx2), .busy(busy2)
   );

   // Expected line level k cycles into a frame: start, data LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] w, input int k,
                                      input int cpb, input int dw);
      int idx;
      idx = k / cpb;
      if (idx == 0) return 1'b0;
      if (idx <= dw) return w[idx-1];
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      valid2 = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         total++;
         if ({tx, ready, busy} !== 3'b110) begin
            bad++;
            $display("FAIL reset cyc%0d: tx/ready/busy=%b required 110", c, {tx, ready, busy});
         end
         total++;
         if ({tx2, ready2, busy2} !== 3'b110) begin
            bad++;
            $display("FAIL reset_min cyc%0d: tx/ready/busy=%b required 110", c, {tx2, ready2, busy2});
         end
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_frame(input logic [DW-1:0] w, input string name);
      din = w;
      valid = 1'b1;
      for (int k = 0; k < FL; k++) begin
         step();
         if (k == 0) begin
            valid = 1'b0;
            din = DW'($urandom);
         end
         total++;
         if ({tx, busy, ready} !== {frame_bit(w, k, CPB, DW), 2'b10}) begin
            bad++;
            $display("FAIL %s cyc%0d: tx/busy/ready=%b required %b", name, k,
                     {tx, busy, ready}, {frame_bit(w, k, CPB, DW), 2'b10});
         end
      end
      step();
      total++;
      if ({tx, busy, ready} !== 3'b101) begin
         bad++;
         $display("FAIL %s idle: tx/busy/ready=%b required 101", name, {tx, busy, ready});
      end
   endtask

   task automatic test_random_frames();
      for (int i = 0; i < 3; i++) begin
         test_frame(DW'($urandom), "random_frame");
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w;
      din = 8'h00;
      valid = 1'b1;
      for (int f = 0; f < 2; f++) begin
         w = (f == 0) ? 8'h00 : 8'hFF;
         for (int k = 0; k < FL; k++) begin
            step();
            if (k == 0) begin
               din = 8'hFF;
               if (f == 1) valid = 1'b0;
            end
            total++;
            if ({tx, busy, ready} !== {frame_bit(w, k, CPB, DW), 2'b10}) begin
               bad++;
               $display("FAIL b2b f%0d cyc%0d: tx/busy/ready=%b required %b", f, k,
                        {tx, busy, ready}, {frame_bit(w, k, CPB, DW), 2'b10});
            end
         end
         step();
         total++;
         if ({tx, busy, ready} !== 3'b101) begin
            bad++;
            $display("FAIL b2b gap f%0d: tx/busy/ready=%b required 101", f, {tx, busy, ready});
         end
      end
   endtask

   task automatic test_ignore_valid();
      logic [DW-1:0] w;
      w = DW'($urandom);
      din = w;
      valid = 1'b1;
      for (int k = 0; k < FL; k++) begin
         step();
         if (k == 0) valid = 1'b0;
         if (k == 10) begin
            valid = 1'b1;
            din = 8'h3C;
         end
         if (k == 11) begin
            valid = 1'b0;
            din = DW'($urandom);
         end
         total++;
         if ({tx, busy, ready} !== {frame_bit(w, k, CPB, DW), 2'b10}) begin
            bad++;
            $display("FAIL ignore cyc%0d: tx/busy/ready=%b required %b", k,
                     {tx, busy, ready}, {frame_bit(w, k, CPB, DW), 2'b10});
         end
      end
      step();
      total++;
      if ({tx, busy, ready} !== 3'b101) begin
         bad++;
         $display("FAIL ignore idle: tx/busy/ready=%b required 101", {tx, busy, ready});
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [DW-1:0] w;
      w = DW'($urandom);
      din = w;
      valid = 1'b1;
      for (int k = 0; k < 4 * CPB; k++) begin
         step();
         if (k == 0) valid = 1'b0;
         total++;
         if (tx !== frame_bit(w, k, CPB, DW)) begin
            bad++;
            $display("FAIL midrst pre cyc%0d: tx=%b required %b", k, tx, frame_bit(w, k, CPB, DW));
         end
      end
      rst_n = 1'b0;
      valid = 1'b1;
      din = DW'($urandom);
      step();
      total++;
      if ({tx, busy, ready} !== 3'b101) begin
         bad++;
         $display("FAIL midrst abort: tx/busy/ready=%b required 101", {tx, busy, ready});
      end
      rst_n = 1'b1;
      valid = 1'b0;
      step();
      total++;
      if ({tx, busy, ready} !== 3'b101) begin
         bad++;
         $display("FAIL midrst no_accept: tx/busy/ready=%b required 101", {tx, busy, ready});
      end
      test_frame(8'h01, "after_reset");
   endtask

   task automatic test_min_config();
      logic [2:0] exp_tx;
      exp_tx = 3'b110;
      din2 = 1'b1;
      valid2 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (k == 0) begin
            valid2 = 1'b0;
            din2 = 1'b0;
         end
         total++;
         if ({tx2, busy2, ready2} !== {exp_tx[k], 2'b10}) begin
            bad++;
            $display("FAIL min cyc%0d: tx/busy/ready=%b required %b", k,
                     {tx2, busy2, ready2}, {exp_tx[k], 2'b10});
         end
      end
      step();
      total++;
      if ({tx2, busy2, ready2} !== 3'b101) begin
         bad++;
         $display("FAIL min idle: tx/busy/ready=%b required 101", {tx2, busy2, ready2});
      end
   endtask

   initial begin
      test_reset();
      test_frame(8'hA5, "frame_a5");
      test_random_frames();
      test_back_to_back();
      test_ignore_valid();
      test_reset_mid_frame();
      test_min_config();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
